// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between N_REQ producers, the write-port arbiter and the FIFO write side.
// master = arbiter view, slave = producers/FIFO view.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    fifo_full;
  logic                    fifo_write_en;
  logic [DATA_W-1:0]       fifo_data;
  logic [N_REQ-1:0]        grant;
  logic                    busy;

  modport master (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_write_en, fifo_data, grant, busy
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_write_en, fifo_data, grant, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, grant held per packet.
// Latency: one IDLE cycle to grant, then writes same-cycle as valid; ready gated by fifo_full.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  fifo_wr_arbiter_if.master  bus
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   grant_q, grant_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;

  logic               sel_valid;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_data;
  logic [PTR_W-1:0]   gidx;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     scan;
  logic               busy;
  logic               xfer;
  logic [CNT_W-1:0]   cnt_inc;
  logic               grant_exit;

  // Grant is one-hot, so OR-ing the masked lanes is a mux on the granted requester.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    gidx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*DATA_W +: DATA_W];
        gidx      = PTR_W'(i);
      end
    end
  end

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (scan >= (PTR_W+1)'(N_REQ)) begin
        scan = scan - (PTR_W+1)'(N_REQ);
      end
      if (!win_found && bus.req_valid[scan[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[PTR_W-1:0];
      end
    end
  end

  assign busy       = (state == GRANT);
  assign xfer       = busy && sel_valid && !bus.fifo_full;
  assign cnt_inc    = beat_cnt + CNT_W'(1);
  assign grant_exit = xfer && (sel_last || (cnt_inc == CNT_W'(MAX_BURST)));

  assign bus.req_ready     = (busy && !bus.fifo_full) ? grant_q : '0;
  assign bus.fifo_write_en = xfer;
  assign bus.fifo_data     = xfer ? sel_data : '0;
  assign bus.grant         = grant_q;
  assign bus.busy          = busy;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          beat_cnt_nxt       = '0;
          state_nxt          = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_cnt_nxt = cnt_inc;
        end
        // A stalled or idle granted requester keeps the grant: packets are never split.
        if (grant_exit) begin
          rr_ptr_nxt = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
          grant_nxt  = '0;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      grant_q  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: inputs driven 1ns after the rising edge, outputs sampled mid-cycle.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk_i = 1'b0;
  logic reset_i;
  int   tests = 0;
  int   fails = 0;
  int   beat;
  logic [7:0] wq[$];

  always #5 clk_i = ~clk_i;

  fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  // Capture every beat the FIFO would accept.
  always @(posedge clk_i) begin
    if (bus.fifo_write_en === 1'b1) wq.push_back(bus.fifo_data);
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] r,
                         input logic we, input logic [7:0] d);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".busy"},  32'(bus.busy), 32'(|g));
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(r));
    chk({tag, ".we"},    32'(bus.fifo_write_en), 32'(we));
    chk({tag, ".data"},  32'(bus.fifo_data), 32'(d));
  endtask

  // exp packs up to four expected bytes, oldest in the low byte.
  task automatic chk_q(input string tag, input logic [31:0] exp, input int n);
    chk({tag, ".size"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wq.size()) chk($sformatf("%s[%0d]", tag, i), 32'(wq[i]), 32'(exp[i*8 +: 8]));
    end
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    bus.req_data[i*W +: W] = v;
  endtask

  initial begin
    reset_i       = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    tick;
    tick;
    reset_i = 1'b0;
    #1 chk_out("rst", 4'b0000, 4'b0000, 1'b0, 8'h00);

    // Two 2-beat packets from req0 and req2.
    wq.delete();
    bus.req_valid = 4'b0101;
    set_data(0, 8'hA0);
    set_data(2, 8'hC0);
    #1 chk_out("t1_idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
    tick;
    #1 chk_out("t1_r0b0", 4'b0001, 4'b0001, 1'b1, 8'hA0);
    tick;
    set_data(0, 8'hA1);
    bus.req_last = 4'b0001;
    #1 chk_out("t1_r0b1", 4'b0001, 4'b0001, 1'b1, 8'hA1);
    tick;
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0000;
    #1 chk_out("t1_gap", 4'b0000, 4'b0000, 1'b0, 8'h00);
    tick;
    #1 chk_out("t1_r2b0", 4'b0100, 4'b0100, 1'b1, 8'hC0);
    tick;
    set_data(2, 8'hC1);
    bus.req_last = 4'b0100;
    #1 chk_out("t1_r2b1", 4'b0100, 4'b0100, 1'b1, 8'hC1);
    tick;
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    #1 chk_out("t1_end", 4'b0000, 4'b0000, 1'b0, 8'h00);
    chk_q("t1_q", 32'hC1C0A1A0, 4);

    // req1 streams 10 beats: bursts of 4, 4, 2 with an idle cycle between.
    wq.delete();
    beat = 0;
    bus.req_valid = 4'b0010;
    #1;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < ((b == 2) ? 2 : 4); k++) begin
        tick;
        set_data(1, 8'(8'h10 + beat));
        bus.req_last = (beat == 9) ? 4'b0010 : 4'b0000;
        #1 chk_out($sformatf("t2_b%0d", beat), 4'b0010, 4'b0010, 1'b1, 8'(8'h10 + beat));
        beat++;
      end
      tick;
      #1 chk_out($sformatf("t2_gap%0d", b), 4'b0000, 4'b0000, 1'b0, 8'h00);
    end
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    chk("t2_cnt", 32'(wq.size()), 32'd10);
    if (wq.size() == 10) begin
      chk("t2_first", 32'(wq[0]), 32'h10);
      chk("t2_last",  32'(wq[9]), 32'h19);
    end

    // All four requesters valid with single-beat packets, starting from reset.
    reset_i = 1'b1;
    tick;
    reset_i = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, 8'(i));
    #1 chk_out("t3_idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      tick;
      #1 chk_out($sformatf("t3_g%0d", k), 4'(1 << (k % 4)), 4'(1 << (k % 4)), 1'b1, 8'(k % 4));
      tick;
      #1 chk_out($sformatf("t3_gap%0d", k), 4'b0000, 4'b0000, 1'b0, 8'h00);
    end
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;

    // req3 packet with a 3-cycle full stall after its first beat.
    wq.delete();
    bus.req_valid = 4'b1000;
    set_data(3, 8'h30);
    tick;
    #1 chk_out("t4_b0", 4'b1000, 4'b1000, 1'b1, 8'h30);
    tick;
    set_data(3, 8'h31);
    bus.fifo_full = 1'b1;
    #1 chk_out("t4_full0", 4'b1000, 4'b0000, 1'b0, 8'h00);
    tick;
    #1 chk_out("t4_full1", 4'b1000, 4'b0000, 1'b0, 8'h00);
    tick;
    #1 chk_out("t4_full2", 4'b1000, 4'b0000, 1'b0, 8'h00);
    tick;
    bus.fifo_full = 1'b0;
    #1 chk_out("t4_b1", 4'b1000, 4'b1000, 1'b1, 8'h31);
    tick;
    set_data(3, 8'h32);
    bus.req_last = 4'b1000;
    #1 chk_out("t4_b2", 4'b1000, 4'b1000, 1'b1, 8'h32);
    tick;
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    #1 chk_out("t4_end", 4'b0000, 4'b0000, 1'b0, 8'h00);
    chk_q("t4_q", 32'h00323130, 3);

    // req0 drops valid mid-packet; req1 must wait behind the lock.
    bus.req_valid = 4'b0011;
    set_data(0, 8'h50);
    set_data(1, 8'h60);
    tick;
    #1 chk_out("t5_r0b0", 4'b0001, 4'b0001, 1'b1, 8'h50);
    tick;
    bus.req_valid = 4'b0010;
    #1 chk_out("t5_hold0", 4'b0001, 4'b0001, 1'b0, 8'h00);
    tick;
    #1 chk_out("t5_hold1", 4'b0001, 4'b0001, 1'b0, 8'h00);
    tick;
    bus.req_valid = 4'b0011;
    set_data(0, 8'h51);
    bus.req_last = 4'b0001;
    #1 chk_out("t5_r0b1", 4'b0001, 4'b0001, 1'b1, 8'h51);
    tick;
    bus.req_valid = 4'b0010;
    bus.req_last  = 4'b0010;
    #1 chk_out("t5_gap", 4'b0000, 4'b0000, 1'b0, 8'h00);
    tick;
    #1 chk_out("t5_r1", 4'b0010, 4'b0010, 1'b1, 8'h60);
    tick;
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;

    // Reset mid-packet from req2; the round-robin pointer must restart at 0.
    bus.req_valid = 4'b0100;
    set_data(2, 8'h70);
    tick;
    #1 chk_out("t6_b0", 4'b0100, 4'b0100, 1'b1, 8'h70);
    tick;
    set_data(2, 8'h71);
    #1 chk_out("t6_b1", 4'b0100, 4'b0100, 1'b1, 8'h71);
    tick;
    reset_i = 1'b1;
    bus.req_valid = 4'b0000;
    tick;
    reset_i = 1'b0;
    #1 chk_out("t6_post", 4'b0000, 4'b0000, 1'b0, 8'h00);
    bus.req_valid = 4'b0101;
    bus.req_last  = 4'b0101;
    set_data(0, 8'h80);
    set_data(2, 8'h82);
    tick;
    #1 chk_out("t6_r0", 4'b0001, 4'b0001, 1'b1, 8'h80);
    tick;
    #1 chk_out("t6_gap", 4'b0000, 4'b0000, 1'b0, 8'h00);
    tick;
    #1 chk_out("t6_r2", 4'b0100, 4'b0100, 1'b1, 8'h82);
    tick;
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that lets N_REQ producers share the single write port of one FIFO instance. Each producer presents beats on a valid/ready handshake. The arbiter grants one producer at a time and holds the grant for a packet (up to MAX_BURST beats). It drives the FIFO write enable and write data, and never writes while the FIFO reports full. It sits directly in front of the FIFO write side; the FIFO read side is untouched.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, beat width in bits
- MAX_BURST, 4, max beats per grant before forced rotation (1..16)

- clk_i  input  1  sole clock; all logic on rising edge
- reset_i  input  1  synchronous, active-high reset
- req_valid_i  input  N_REQ  per-requester beat valid
- req_last_i  input  N_REQ  per-requester last-beat-of-packet flag, qualified by valid
- req_data_i  input  N_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W]
- req_ready_o  output  N_REQ  per-requester beat accepted this cycle when valid&ready
- fifo_full_i  input  1  full flag from FIFO
- fifo_write_en_o  output  1  FIFO write strobe
- fifo_data_o  output  DATA_W  FIFO write data
- grant_o  output  N_REQ  one-hot current grant, 0 when idle
- busy_o  output  1  1 while in GRANT state

## Operation
- FSM states: IDLE, GRANT.
- IDLE:
  - grant_o=0, all req_ready_o=0.
  - If any req_valid_i, select the winner: the first asserted index scanning from rr_ptr upward, modulo N_REQ.
  - Register grant_o=onehot(winner), clear beat_cnt, go to GRANT.
- GRANT (granted index g):
  - req_ready_o[g] = !fifo_full_i; all other ready bits are 0.
  - A beat transfers when req_valid_i[g] & req_ready_o[g]. On a transfer, fifo_write_en_o=1, fifo_data_o=req_data_i[g], beat_cnt+1.
  - fifo_write_en_o, fifo_data_o and req_ready_o are combinational from registered grant/state plus inputs. There is no extra data register.
- GRANT exit:
  - Condition: a transfer with req_last_i[g]=1, or a transfer making beat_cnt==MAX_BURST.
  - Action: rr_ptr <= (g+1) mod N_REQ, grant_o <= 0, go to IDLE.
  - The exit is evaluated on the transferring cycle only.
- Packet lock: if req_valid_i[g] drops mid-packet, the grant is held indefinitely. Other requesters wait.
- fifo_full_i high in GRANT: ready=0 and no write. Grant and beat_cnt hold. Resume the cycle full deasserts.
- fifo_data_o when no write: drives 0.
- beat_cnt width: $clog2(MAX_BURST+1). It never exceeds MAX_BURST.
- Requesters must hold data/last stable while valid&!ready. The arbiter does not check this.

## Timing
- Reset (synchronous) takes effect at the next edge from any state:
  - State=IDLE, rr_ptr=0, beat_cnt=0.
  - grant_o=0, busy_o=0, req_ready_o=0, fifo_write_en_o=0, fifo_data_o=0.
  - A packet in flight is abandoned. The FIFO is not told, and already-written beats remain in it.
- Arbitration latency: valid seen in IDLE at edge k gives grant_o/busy_o high after edge k+1. First ready and write occur in cycle k+1, combinationally with valid.
- Throughput in GRANT: 1 beat/cycle while valid and !full.
- Turnaround: exactly one IDLE cycle between consecutive grants, so max sustained rate is MAX_BURST/(MAX_BURST+1).
- No write occurs in any cycle where fifo_full_i=1. This holds because ready is gated in the same cycle.
- Simultaneous last and MAX_BURST: a single exit, same behaviour.
- Requester valid arriving during another's GRANT is serviced only after that grant ends, in round-robin order.

## Test plan
- Reset, then req_valid_i=4'b0101, each sending a 2-beat packet (last on beat 2), fifo_full_i=0 → grant_o=0001 for 2 cycles, then 1 idle cycle, then 0100 for 2 cycles. FIFO receives 4 beats in order req0,req0,req2,req2.
- Requester 1 streams 10 beats with no last → writes in bursts of 4,4,2 with 1 idle cycle between. With only req1 valid, it is regranted each time. rr_ptr=2 after each burst.
- All 4 requesters continuously valid with single-beat packets (last=1) → grant order 0,1,2,3,0,…, one write every 2 cycles, each beat data=requester index.
- During GRANT to req3, assert fifo_full_i for 3 cycles mid-packet → fifo_write_en_o=0 and req_ready_o[3]=0 for those 3 cycles, grant_o held at 1000. The transfer resumes the cycle full drops, with no beat lost or duplicated.
- req0 granted, valid drops after beat 1 while req1 valid → grant_o stays 0001 and req_ready_o[1]=0 until req0 completes with last.
- Assert reset_i for 1 cycle after 2 beats of a 4-beat packet → next cycle all outputs 0 and state IDLE. A new request from req2 is granted first, since rr_ptr=0 and req0/req1 are idle.
